gpio_input_conditioner: RTL and testbench
=========================================

Name: gpio_input_conditioner

Overview:
- Conditions raw board inputs (switches, buttons, Pmod inputs) before they reach the SoC core's GPIO input ports.
- Per bit, it synchronizes the raw input into the clock domain and then debounces it.
- It also produces one-cycle rise and fall pulses and, optionally, sticky rise flags with an interrupt line.
- One instance is placed per GPIO input bank in the board top level, between the pins and the core.

Parameters:
- WIDTH, 8, number of independent input bits.
- SYNC_STAGES, 2, synchronizer flip-flop depth; legal values ≥2.
- DEBOUNCE_CYCLES, 100000, consecutive cycles a synchronized value must hold before it is accepted; legal values ≥1.
- CNT_W, $clog2(DEBOUNCE_CYCLES+1), counter width; derived, do not override.

Ports:
- clock, input, 1, sole clock; all state on its rising edge.
- reset_n, input, 1, asynchronous active-low reset.
- raw_in, input, WIDTH, asynchronous pin inputs.
- clean_out, output, WIDTH, debounced level; drives the core GPIO input.
- rise_pulse, output, WIDTH, one-cycle pulse per bit on each accepted 0→1 transition.
- fall_pulse, output, WIDTH, one-cycle pulse per bit on each accepted 1→0 transition.
- sticky_rise, output, WIDTH, latched rise flags; present only with the optional feature.
- sticky_clr, input, WIDTH, per-bit clear for sticky_rise.
- irq, output, 1, OR of sticky_rise.

Behaviour:
- Reset (reset_n low, asynchronous) clears the following to 0: all sync flops, counters, clean_out, rise_pulse, fall_pulse, sticky_rise and irq. Release of reset is synchronous in effect; the first state update occurs on the first rising edge with reset_n high.
- Reset asserted mid-debounce discards the partial count. After release, bits whose raw input is 1 debounce from 0 as a normal rise and produce a rise_pulse.
- Synchronizer: the per-bit shift chain is SYNC_STAGES deep, and sync[i] is the last stage.
- Debounce, independently per bit:
  - If sync[i] equals clean_out[i], the counter is set to 0.
  - Otherwise, if the counter equals DEBOUNCE_CYCLES-1, then clean_out[i] takes sync[i] and the counter is set to 0.
  - Otherwise the counter increments.
- Any return of sync to clean_out before acceptance restarts the count. Glitches shorter than DEBOUNCE_CYCLES cycles are therefore fully rejected, and clean_out never toggles.
- Latency: when raw_in changes and then holds, clean_out changes on exactly the (SYNC_STAGES + DEBOUNCE_CYCLES)-th rising edge, counting the first edge that samples the new value as edge 1.
- rise_pulse[i] and fall_pulse[i] are registered and asserted in the same cycle clean_out[i] updates, for exactly one cycle. The two are never high together on the same bit.
- Counter saturation: the counter never exceeds DEBOUNCE_CYCLES-1, so no wrap-around is possible.
- DEBOUNCE_CYCLES=1: clean_out follows sync with one cycle of delay.
- Bits are fully independent; simultaneous transitions on several bits produce simultaneous pulses.

Optional Feature:
- Macro: GPIO_COND_STICKY_EN.
- When defined:
  - sticky_rise[i] is set in the cycle after rise_pulse[i] and holds until a cycle with sticky_clr[i]=1.
  - If set and clear coincide, set wins.
  - irq is registered as the OR-reduction of sticky_rise, with one cycle of latency.
- When undefined:
  - sticky_rise is tied to 0 and irq is tied to 0.
  - sticky_clr is ignored, with no logic generated.
  - Ports remain present, so the top level is unchanged.

Test Plan:
Bench configuration: WIDTH=8, SYNC_STAGES=2, DEBOUNCE_CYCLES=4.
1. Reset with raw_in=8'hFF, release, hold -> clean_out=8'h00 through edge 5; clean_out=8'hFF on edge 6; rise_pulse=8'hFF for exactly one cycle; fall_pulse stays 0.
2. From clean 8'h00, pulse raw_in[3] high for 3 cycles, then low -> clean_out stays 8'h00 and no pulses occur; a later 4-cycle hold of raw_in[3]=1 produces clean_out[3]=1 on edge 6.
3. From clean 8'h01, drop raw_in[0] to 0 and hold -> clean_out=8'h00 on edge 6; fall_pulse=8'h01 for one cycle.
4. Assert reset_n low for 1 ns between clock edges mid-count (counter=2) -> all outputs read 0 immediately with no clock edge; after release, a full 6-edge latency elapses before the rise.
5. With GPIO_COND_STICKY_EN, rise on bit 5 -> sticky_rise=8'h20 one cycle after rise_pulse and irq=1 one cycle later; sticky_clr=8'h20 coincident with a new bit-5 rise -> flag stays set; sticky_clr alone -> sticky_rise=0, then irq=0 the next cycle.
6. Without GPIO_COND_STICKY_EN, repeat scenario 5 -> sticky_rise=8'h00 and irq=0 throughout.

Source files
------------

// File: rtl/gpio_input_conditioner.sv
// Per-bit synchronizer + debouncer for board GPIO inputs, with rise/fall pulses.
// Optional sticky rise flags and irq are enabled by defining GPIO_COND_STICKY_EN.

module gpio_cond_lane #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 100000,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic clock,
  input  logic reset_n,
  input  logic raw,
  output logic clean,
  output logic rise,
  output logic fall
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   clean_d, rise_d, fall_d;

  assign sync = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) sync_q <= '0;
    else          sync_q <= {sync_q[SYNC_STAGES-2:0], raw};
  end

  // Count only while the synchronized level disagrees with the accepted one;
  // any agreement restarts the window, so short glitches never get through.
  always_comb begin
    cnt_d   = cnt_q;
    clean_d = clean;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    if (sync == clean) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_MAX) begin
      cnt_d   = '0;
      clean_d = sync;
      rise_d  = sync;
      fall_d  = ~sync;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
      clean <= 1'b0;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      clean <= clean_d;
      rise  <= rise_d;
      fall  <= fall_d;
    end
  end

endmodule

module gpio_input_conditioner #(
  parameter int WIDTH           = 8,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 100000,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] raw_in,
  output logic [WIDTH-1:0] clean_out,
  output logic [WIDTH-1:0] rise_pulse,
  output logic [WIDTH-1:0] fall_pulse,
  output logic [WIDTH-1:0] sticky_rise,
  input  logic [WIDTH-1:0] sticky_clr,
  output logic             irq
);

  gpio_cond_lane #(
    .SYNC_STAGES    (SYNC_STAGES),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W)
  ) u_lane [WIDTH-1:0] (
    .clock  (clock),
    .reset_n(reset_n),
    .raw    (raw_in),
    .clean  (clean_out),
    .rise   (rise_pulse),
    .fall   (fall_pulse)
  );

`ifdef GPIO_COND_STICKY_EN
  // Set has priority so a rise landing on the clear cycle is never lost.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sticky_rise <= '0;
      irq         <= 1'b0;
    end else begin
      sticky_rise <= (sticky_rise & ~sticky_clr) | rise_pulse;
      irq         <= |sticky_rise;
    end
  end
`else
  logic unused_sticky_clr;
  assign unused_sticky_clr = ^sticky_clr;
  assign sticky_rise       = '0;
  assign irq               = 1'b0;
`endif

endmodule

// File: tb/tb_gpio_input_conditioner.sv
// Directed bench for gpio_input_conditioner (WIDTH=8, SYNC_STAGES=2, DEBOUNCE_CYCLES=4).
// Sticky expectations follow GPIO_COND_STICKY_EN as defined for the build.

module tb_gpio_input_conditioner;

`ifdef GPIO_COND_STICKY_EN
  localparam logic STK = 1'b1;
`else
  localparam logic STK = 1'b0;
`endif
  localparam logic [7:0] SMASK = STK ? 8'hFF : 8'h00;

  logic       clock;
  logic       reset_n;
  logic [7:0] raw_in;
  logic [7:0] clean_out, rise_pulse, fall_pulse, sticky_rise, sticky_clr;
  logic       irq;

  int checks = 0;
  int errors = 0;

  gpio_input_conditioner #(
    .WIDTH          (8),
    .SYNC_STAGES    (2),
    .DEBOUNCE_CYCLES(4)
  ) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .raw_in     (raw_in),
    .clean_out  (clean_out),
    .rise_pulse (rise_pulse),
    .fall_pulse (fall_pulse),
    .sticky_rise(sticky_rise),
    .sticky_clr (sticky_clr),
    .irq        (irq)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset(input logic [7:0] v);
    reset_n    = 1'b0;
    raw_in     = v;
    sticky_clr = 8'h00;
    #2;
    reset_n = 1'b1;
  endtask

  task automatic test_reset;
    logic [7:0] ec, er;
    raw_in     = 8'hFF;
    sticky_clr = 8'h00;
    reset_n    = 1'b0;
    #2;
    checks++;
    if ({clean_out, rise_pulse, fall_pulse, sticky_rise, irq} !== 33'd0) begin
      errors++;
      $display("FAIL reset_state got %h/%h/%h/%h/%b want all 0",
               clean_out, rise_pulse, fall_pulse, sticky_rise, irq);
    end
    reset_n = 1'b1;
    for (int e = 1; e <= 7; e++) begin
      tick;
      ec = (e >= 6) ? 8'hFF : 8'h00;
      er = (e == 6) ? 8'hFF : 8'h00;
      checks++;
      if (clean_out !== ec) begin
        errors++;
        $display("FAIL reset_rise_clean edge %0d got %h want %h", e, clean_out, ec);
      end
      checks++;
      if (rise_pulse !== er || fall_pulse !== 8'h00) begin
        errors++;
        $display("FAIL reset_rise_pulse edge %0d got rise %h fall %h want rise %h fall 00",
                 e, rise_pulse, fall_pulse, er);
      end
    end
  endtask

  task automatic test_glitch;
    logic [7:0] ec, er;
    do_reset(8'h00);
    repeat (8) tick;
    raw_in = 8'h08;
    repeat (3) tick;
    raw_in = 8'h00;
    for (int e = 1; e <= 8; e++) begin
      tick;
      checks++;
      if (clean_out !== 8'h00 || rise_pulse !== 8'h00 || fall_pulse !== 8'h00) begin
        errors++;
        $display("FAIL glitch_reject cycle %0d got clean %h rise %h fall %h want 00/00/00",
                 e, clean_out, rise_pulse, fall_pulse);
      end
    end
    raw_in = 8'h08;
    for (int e = 1; e <= 7; e++) begin
      tick;
      ec = (e >= 6) ? 8'h08 : 8'h00;
      er = (e == 6) ? 8'h08 : 8'h00;
      checks++;
      if (clean_out !== ec || rise_pulse !== er) begin
        errors++;
        $display("FAIL glitch_hold edge %0d got clean %h rise %h want clean %h rise %h",
                 e, clean_out, rise_pulse, ec, er);
      end
    end
  endtask

  task automatic test_fall;
    logic [7:0] ec, ef;
    do_reset(8'h01);
    repeat (8) tick;
    checks++;
    if (clean_out !== 8'h01) begin
      errors++;
      $display("FAIL fall_setup got %h want 01", clean_out);
    end
    raw_in = 8'h00;
    for (int e = 1; e <= 7; e++) begin
      tick;
      ec = (e >= 6) ? 8'h00 : 8'h01;
      ef = (e == 6) ? 8'h01 : 8'h00;
      checks++;
      if (clean_out !== ec || fall_pulse !== ef || rise_pulse !== 8'h00) begin
        errors++;
        $display("FAIL fall edge %0d got clean %h fall %h rise %h want clean %h fall %h rise 00",
                 e, clean_out, fall_pulse, rise_pulse, ec, ef);
      end
    end
  endtask

  task automatic test_mid_reset;
    logic [7:0] ec, er;
    do_reset(8'h80);
    repeat (8) tick;
    raw_in = 8'h81;
    repeat (4) tick;
    checks++;
    if (clean_out !== 8'h80) begin
      errors++;
      $display("FAIL midreset_pre got %h want 80", clean_out);
    end
    reset_n = 1'b0;
    #1;
    checks++;
    if ({clean_out, rise_pulse, fall_pulse, sticky_rise, irq} !== 33'd0) begin
      errors++;
      $display("FAIL midreset_async got %h/%h/%h/%h/%b want all 0",
               clean_out, rise_pulse, fall_pulse, sticky_rise, irq);
    end
    reset_n = 1'b1;
    #1;
    for (int e = 1; e <= 7; e++) begin
      tick;
      ec = (e >= 6) ? 8'h81 : 8'h00;
      er = (e == 6) ? 8'h81 : 8'h00;
      checks++;
      if (clean_out !== ec || rise_pulse !== er) begin
        errors++;
        $display("FAIL midreset_rise edge %0d got clean %h rise %h want clean %h rise %h",
                 e, clean_out, rise_pulse, ec, er);
      end
    end
  endtask

  task automatic test_sticky;
    logic [7:0] es, er;
    logic       ei;
    do_reset(8'h00);
    repeat (8) tick;
    raw_in = 8'h20;
    for (int e = 1; e <= 8; e++) begin
      tick;
      er = (e == 6) ? 8'h20 : 8'h00;
      es = (e >= 7) ? (8'h20 & SMASK) : 8'h00;
      ei = (e >= 8) && STK;
      checks++;
      if (rise_pulse !== er || sticky_rise !== es || irq !== ei) begin
        errors++;
        $display("FAIL sticky_set edge %0d got rise %h sticky %h irq %b want %h %h %b",
                 e, rise_pulse, sticky_rise, irq, er, es, ei);
      end
    end
    raw_in = 8'h00;
    repeat (8) tick;
    checks++;
    if (clean_out !== 8'h00 || sticky_rise !== (8'h20 & SMASK) || irq !== STK) begin
      errors++;
      $display("FAIL sticky_hold got clean %h sticky %h irq %b want 00 %h %b",
               clean_out, sticky_rise, irq, 8'h20 & SMASK, STK);
    end
    raw_in = 8'h20;
    repeat (6) tick;
    checks++;
    if (rise_pulse !== 8'h20) begin
      errors++;
      $display("FAIL sticky_rerise got rise %h want 20", rise_pulse);
    end
    sticky_clr = 8'h20;
    tick;
    checks++;
    if (sticky_rise !== (8'h20 & SMASK) || irq !== STK) begin
      errors++;
      $display("FAIL sticky_set_wins got sticky %h irq %b want %h %b",
               sticky_rise, irq, 8'h20 & SMASK, STK);
    end
    tick;
    checks++;
    if (sticky_rise !== 8'h00 || irq !== STK) begin
      errors++;
      $display("FAIL sticky_clear got sticky %h irq %b want 00 %b", sticky_rise, irq, STK);
    end
    sticky_clr = 8'h00;
    tick;
    checks++;
    if (sticky_rise !== 8'h00 || irq !== 1'b0) begin
      errors++;
      $display("FAIL sticky_irq_drop got sticky %h irq %b want 00 0", sticky_rise, irq);
    end
  endtask

  initial begin
    test_reset;
    test_glitch;
    test_fall;
    test_mid_reset;
    test_sticky;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
